uart_rx: RTL and testbench

//   8N1 UART receiver: the receive end of the team's UART_TX serial link, same bit timing.

---
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Synchronises the rx pin, qualifies the start bit at
// mid-bit, samples eight data bits LSB first at mid-bit and checks the stop
// bit. A good byte is presented with a one-cycle data_valid pulse; a low stop
// bit produces a one-cycle frame_err pulse and the byte is dropped.
module uart_rx #(
  parameter int unsigned freq = 27000000,
  parameter int unsigned baud = 3000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  // Clocks per bit and half-bit; counters compare against the last count.
  localparam int unsigned W = freq / baud;
  localparam int unsigned H = W / 2;
  localparam logic [7:0] W_LAST = 8'(W - 1);
  localparam logic [7:0] H_LAST = 8'(H - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [1:0]  settle_q, settle_d;
  logic        armed_q, armed_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        data_valid_q, data_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        busy_q, busy_d;
  logic        rx_s;

  assign rx_s       = sync2_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

  // Next-state and output decode for the receive FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // variable unassigned (that would infer a latch); blocking '=' is correct
    // here because this is combinational logic.
    state_d      = state_q;
    sync1_d      = rx;
    sync2_d      = sync1_q;
    settle_d     = {settle_q[0], 1'b1};
    armed_d      = armed_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The sync flops are preset high by reset, so their first two outputs
        // are not real line observations; only arm once they hold pin data.
        if (rx_s) begin
          if (settle_q[1]) armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          cnt_d   = 8'd0;
        end
      end
      START: begin
        if (cnt_q == H_LAST) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = 8'd0;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;  // glitch shorter than half a bit
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (cnt_q == W_LAST) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = 8'd0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (cnt_q == W_LAST) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          if (rx_s) begin
            data_d       = shift_q;
            data_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            armed_d     = 1'b0;  // a held-low line must go high before re-arming
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every flop samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      settle_q     <= 2'b00;
      armed_q      <= 1'b0;
      cnt_q        <= 8'd0;
      idx_q        <= 3'd0;
      shift_q      <= 8'd0;
      data_q       <= 8'd0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      settle_q     <= settle_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an ideal 9-clock/bit transmitter drives the line, each
// issued frame pushes its expected pulse (kind, byte, cycle) into a queue and
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_uart_rx;

  localparam int BIT_CLKS = 9;   // 27 MHz / 3 Mbaud
  localparam int LATENCY  = 88;  // driver cycle of the start fall -> pulse cycle

  typedef struct {
    bit         err;
    logic [7:0] byte_v;
    int         due;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  exp_t       sb[$];
  int         cyc;
  int         n_cmp;
  int         n_fail;
  int         busy_cnt;
  logic [7:0] last_good;

  uart_rx #(.freq(27000000), .baud(3000000)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cyc);
    end
  endtask

  // Hold the line at val for n bit-clocks; the driver always sits #1 after an edge.
  task automatic drive(input logic val, input int n);
    rx = val;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Ideal transmitter: start, 8 data bits LSB first, stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input bit expect_pulse);
    exp_t e;
    if (expect_pulse) begin
      e.err    = !stop_ok;
      e.byte_v = b;
      e.due    = cyc + LATENCY;
      sb.push_back(e);
    end
    drive(1'b0, BIT_CLKS);
    for (int k = 0; k < 8; k++) drive(b[k], BIT_CLKS);
    drive(stop_ok, BIT_CLKS);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"}, data, 0);
    check({tag, "_data_valid"}, data_valid, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: pop the expected pulse and compare kind, data and arrival cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_good = 8'h00;
    end else begin
      if (busy) busy_cnt++;
      if (data_valid || frame_err) begin
        check("pulse_exclusive", data_valid && frame_err, 0);
        if (sb.size() == 0) begin
          check("pulse_expected", 0, 1);
        end else begin
          e = sb.pop_front();
          check("pulse_kind_err", frame_err, e.err);
          check("pulse_data", data, e.err ? last_good : e.byte_v);
          check("pulse_cycle", cyc, e.due);
          if (!e.err) last_good = e.byte_v;
        end
      end
    end
  end

  initial begin
    int   gap;
    logic stop_ok;
    logic [7:0] b;

    cyc      = 0;
    n_cmp    = 0;
    n_fail   = 0;
    busy_cnt = 0;
    rst      = 1'b1;
    rx       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    drive(1'b1, 10);

    // 1: single frame 0xA5
    send_frame(8'hA5, 1'b1, 1'b1);
    drive(1'b1, 10);

    // 2: back-to-back 0x00 then 0xFF with no idle gap
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    drive(1'b1, 10);

    // 3: three-clock low glitch, rejected at half-bit
    busy_cnt = 0;
    drive(1'b0, 3);
    drive(1'b1, 20);
    check("glitch_busy_cycles", busy_cnt, 4);

    // 4: bad stop bit, line held low, then a good frame after it rises
    send_frame(8'h3C, 1'b0, 1'b1);
    drive(1'b0, 50);
    drive(1'b1, 5);
    send_frame(8'h3C, 1'b1, 1'b1);
    drive(1'b1, 10);

    // 5: reset pulse during bit 4 of 0x81 aborts the frame
    drive(1'b0, BIT_CLKS);
    drive(1'b1, BIT_CLKS);
    for (int k = 1; k < 4; k++) drive(1'b0, BIT_CLKS);
    drive(1'b0, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs_zero("midframe_reset");
    drive(1'b0, 4);
    drive(1'b0, 2 * BIT_CLKS);
    drive(1'b1, 2 * BIT_CLKS);
    drive(1'b1, 5);
    send_frame(8'h81, 1'b1, 1'b1);
    drive(1'b1, 10);

    // 6: transmitter stream 0x00, 0x55, 0xAA, 0xFF back to back
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1);
    send_frame(8'hAA, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    drive(1'b1, 3);

    // Randomised frames, idle gaps and occasional bad stop bits
    for (int i = 0; i < 30; i++) begin
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      gap     = $urandom_range(0, 12);
      if (!stop_ok && gap < 2) gap = 2;
      send_frame(b, stop_ok, 1'b1);
      if (gap > 0) drive(1'b1, gap);
    end
    drive(1'b1, 1);

    // Drain: every issued frame must have produced its pulse.
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    drive(1'b1, 5);
    check("scoreboard_drained", sb.size(), 0);
    check("idle_after_drain", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
